usb_wire_event_bridge: RTL

Multi-port co-simulation bridge between the USB wire interface of one or more USB host/slave cores and the SID transaction model. Per port, it resolves the core's driven or pulled-up line state and timestamps every line-state change into a shared event FIFO that SID drains. It also replays SID-supplied line states, each with a programmable dwell, onto the cores' wire inputs. It sits in the co-sim wrapper level, in the USB clock domain, and replaces the single-port combinational line latch.

---
 rtl/usb_wire_pkg.sv | 39 +++
 rtl/usb_evt_fifo.sv | 53 +++++
 rtl/usb_wire_event_bridge.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_wire_pkg.sv
// Shared constants, RX replay FSM states and event-word field offsets for the
// USB wire <-> SID event bridge.
package usb_wire_pkg;

    localparam logic [1:0] SE0  = 2'b00;
    localparam logic [1:0] J_FS = 2'b10;
    localparam logic [1:0] K_FS = 2'b01;
    localparam logic [1:0] SE1  = 2'b11;

    localparam int unsigned DWELL_W = 16;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_APPLY = 2'd1,
        RX_DWELL = 2'd2
    } rx_state_e;

    // Event word layout, MSB first: {port, oe, dp, dm, ts}
    function automatic int unsigned evt_ts_lsb();
        return 0;
    endfunction

    function automatic int unsigned evt_line_lsb(int unsigned ts_w);
        return ts_w;
    endfunction

    function automatic int unsigned evt_oe_bit(int unsigned ts_w);
        return ts_w + 2;
    endfunction

    function automatic int unsigned evt_port_lsb(int unsigned ts_w);
        return ts_w + 3;
    endfunction

    function automatic int unsigned evt_width(int unsigned pw, int unsigned ts_w);
        return pw + 3 + ts_w;
    endfunction

endpackage

// File: rtl/usb_evt_fifo.sv
// Synchronous show-ahead FIFO: head is valid whenever empty is low; a pop on a
// full FIFO frees the slot for a same-cycle push.
module usb_evt_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/usb_wire_event_bridge.sv
// Multi-port USB wire <-> SID bridge: timestamps every resolved line-state change
// into an event FIFO and replays SID line states onto the cores with a dwell.
module usb_wire_event_bridge
    import usb_wire_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 1,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned FIFO_ADDR_WIDTH = 4,
    parameter int unsigned TS_WIDTH        = 16,
    localparam int unsigned PW             = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int unsigned EVT_W          = evt_width(PW, TS_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [2*NUM_PORTS-1:0] core_data_i,
    input  logic [NUM_PORTS-1:0]   core_oe_i,
    input  logic [NUM_PORTS-1:0]   dp_pullup_i,
    input  logic [NUM_PORTS-1:0]   dm_pullup_i,
    output logic [2*NUM_PORTS-1:0] wire_out_o,
    output logic [2*NUM_PORTS-1:0] wire_in_o,
    output logic                   evt_valid_o,
    input  logic                   evt_ready_i,
    output logic [EVT_W-1:0]       evt_data_o,
    input  logic                   rx_valid_i,
    output logic                   rx_ready_o,
    input  logic [PW-1:0]          rx_port_i,
    input  logic [1:0]             rx_line_i,
    input  logic [DWELL_W-1:0]     rx_dwell_i,
    input  logic                   clr_i,
    output logic                   coalesce_o,
    output logic                   drop_o
);

    localparam int unsigned TS_LSB   = evt_ts_lsb();
    localparam int unsigned LINE_LSB = evt_line_lsb(TS_WIDTH);
    localparam int unsigned OE_BIT   = evt_oe_bit(TS_WIDTH);
    localparam int unsigned PORT_LSB = evt_port_lsb(TS_WIDTH);

    logic [NUM_PORTS-1:0][1:0]          resolved;
    logic [NUM_PORTS-1:0]               change;
    logic [NUM_PORTS-1:0]               oe_q;
    logic [NUM_PORTS-1:0]               pending;
    logic [NUM_PORTS-1:0]               grant;
    logic [NUM_PORTS-1:0]               ent_oe;
    logic [NUM_PORTS-1:0][1:0]          ent_line;
    logic [NUM_PORTS-1:0][TS_WIDTH-1:0] ent_ts;
    logic [TS_WIDTH-1:0]                ts_q;
    logic                               push;
    logic [EVT_W-1:0]                   push_data;
    logic                               pop;
    logic                               can_push;
    logic                               fifo_full;
    logic                               fifo_empty;

    // Line resolution and change detection against the registered line/oe
    always_comb begin
        resolved = '0;
        change   = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (core_oe_i[p]) begin
                resolved[p] = core_data_i[2*p +: 2];
            end else begin
                case ({dp_pullup_i[p], dm_pullup_i[p]})
                    2'b10:   resolved[p] = J_FS;
                    2'b01:   resolved[p] = K_FS;
                    2'b11:   resolved[p] = SE1;
                    default: resolved[p] = SE0;
                endcase
            end
            change[p] = (resolved[p] != wire_out_o[2*p +: 2]) || (core_oe_i[p] != oe_q[p]);
        end
    end

    assign pop      = evt_valid_o && evt_ready_i;
    assign can_push = !fifo_full || pop;

    // Fixed-priority push arbiter, lowest pending port wins
    always_comb begin
        grant     = '0;
        push      = 1'b0;
        push_data = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            if (pending[p] && can_push && !push) begin
                grant[p]                     = 1'b1;
                push                         = 1'b1;
                push_data[PORT_LSB +: PW]    = PW'(p);
                push_data[OE_BIT]            = ent_oe[p];
                push_data[LINE_LSB +: 2]     = ent_line[p];
                push_data[TS_LSB +: TS_WIDTH] = ent_ts[p];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wire_out_o <= '0;
            oe_q       <= '0;
            pending    <= '0;
            ent_oe     <= '0;
            ent_line   <= '0;
            ent_ts     <= '0;
            ts_q       <= '0;
            coalesce_o <= 1'b0;
        end else begin
            wire_out_o <= resolved;
            oe_q       <= core_oe_i;
            ts_q       <= ts_q + TS_WIDTH'(1);
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (change[p]) begin
                    pending[p]  <= 1'b1;
                    ent_oe[p]   <= core_oe_i[p];
                    ent_line[p] <= resolved[p];
                    ent_ts[p]   <= ts_q;
                end else if (grant[p]) begin
                    pending[p] <= 1'b0;
                end
            end
            // Only an entry that is not leaving this cycle is actually lost
            if (|(change & pending & ~grant)) begin
                coalesce_o <= 1'b1;
            end else if (clr_i) begin
                coalesce_o <= 1'b0;
            end
        end
    end

    usb_evt_fifo #(
        .WIDTH      (EVT_W),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (evt_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid_o = !fifo_empty;

    rx_state_e          rx_state;
    logic [PW-1:0]      cmd_port;
    logic [1:0]         cmd_line;
    logic [DWELL_W-1:0] cmd_dwell;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               cmd_in_range;

    assign cmd_in_range = (int'(cmd_port) < int'(NUM_PORTS));

    // RX replay FSM; rx_ready_o tracks the next state so it stays registered
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state   <= RX_IDLE;
            rx_ready_o <= 1'b1;
            wire_in_o  <= '0;
            cmd_port   <= '0;
            cmd_line   <= SE0;
            cmd_dwell  <= '0;
            dwell_cnt  <= '0;
            drop_o     <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_valid_i) begin
                        cmd_port   <= rx_port_i;
                        cmd_line   <= rx_line_i;
                        cmd_dwell  <= rx_dwell_i;
                        rx_state   <= RX_APPLY;
                        rx_ready_o <= 1'b0;
                    end
                end
                RX_APPLY: begin
                    for (int p = 0; p < int'(NUM_PORTS); p++) begin
                        if (int'(cmd_port) == p) begin
                            wire_in_o[2*p +: 2] <= cmd_line;
                        end
                    end
                    dwell_cnt <= cmd_dwell;
                    if (cmd_dwell == '0) begin
                        rx_state   <= RX_IDLE;
                        rx_ready_o <= 1'b1;
                    end else begin
                        rx_state <= RX_DWELL;
                    end
                end
                RX_DWELL: begin
                    if (dwell_cnt <= DWELL_W'(1)) begin
                        rx_state   <= RX_IDLE;
                        rx_ready_o <= 1'b1;
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end
                default: begin
                    rx_state   <= RX_IDLE;
                    rx_ready_o <= 1'b1;
                end
            endcase
            if (rx_state == RX_APPLY && !cmd_in_range) begin
                drop_o <= 1'b1;
            end else if (clr_i) begin
                drop_o <= 1'b0;
            end
        end
    end

endmodule
